project_select_ctrl: RTL and testbench
======================================

PROJECT_SELECT_CTRL -- requirements
Module: project_select_ctrl

Interface
REQ-001 SHALL have parameter NUM_PROJECTS, default 8, number of multiplexed projects (2..16).
REQ-002 SHALL have parameter IO_PADS, default 38, user IO pad count (33..64).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h30000000, register window base.
REQ-004 SHALL have parameter SWITCH_RST_CYCLES, default 16, project reset hold length (1..255).
REQ-005 SHALL have port wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port wb_rst_i  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each; wbs_sel_i  in  4; wbs_adr_i, wbs_dat_i  in  32 -- Wishbone slave request.
REQ-008 SHALL have ports wbs_ack_o  out  1; wbs_dat_o  out  32 -- Wishbone response.
REQ-009 SHALL have ports io_in  in  IO_PADS; io_out  out  IO_PADS; io_oeb  out  IO_PADS (active-low enable).
REQ-010 SHALL have ports proj_io_in  out  NUM_PROJECTS*IO_PADS; proj_io_out  in  NUM_PROJECTS*IO_PADS (project p at slice [p*IO_PADS +: IO_PADS]).
REQ-011 SHALL have ports proj_rst  out  NUM_PROJECTS (per-project reset); la_rst_i  in  1 (external reset request for active project); switch_busy  out  1.

Function
REQ-012 Registers (offset from BASE_ADDR): 0x00 ACTIVE, 0x04 OEB_LO, 0x08 OEB_HI, 0x0C STATUS, 0x10 SWRST; only these five offsets acked.
REQ-013 Valid = cyc & stb; ack SHALL pulse one cycle, asserted the cycle after valid to a mapped offset, never on two consecutive cycles; wbs_dat_o = read data during ack, else 0.
REQ-014 Write = valid & we & (sel != 0); read = valid & !we.
REQ-015 ACTIVE write (sel[0] required) with dat[7:0] < NUM_PROJECTS and FSM IDLE SHALL start a switch to that index; same index as current SHALL still run full sequence.
REQ-016 ACTIVE write with index >= NUM_PROJECTS SHALL be acked, ignored, set STATUS.range_err; during busy SHALL be acked, ignored, set STATUS.busy_err.
REQ-017 OEB_LO/OEB_HI writes SHALL update oeb_reg[31:0] / oeb_reg[IO_PADS-1:32] only when sel == 4'hF; partial writes acked, no effect.
REQ-018 STATUS read = {16'b0, switch_count[7:0], busy, busy_err, range_err, 1'b0, active[3:0]}; any STATUS write clears both error flags.
REQ-019 switch_count SHALL increment on each completed switch, wrapping 255 -> 0.
REQ-020 SWRST write SHALL load sw_rst[NUM_PROJECTS-1:0]; proj_rst[p] = sw_rst[p] | fsm_rst[p] | (la_rst_i & p == active).
REQ-021 FSM states IDLE, ISOLATE, RESET: IDLE->ISOLATE on accepted ACTIVE write (active <= new index same edge); ISOLATE->RESET after 1 cycle; RESET held exactly SWITCH_RST_CYCLES cycles, then IDLE.
REQ-022 In ISOLATE and RESET: io_out = 0, io_oeb = all ones, all proj_io_in = 0; fsm_rst[active] = 1 in RESET only; switch_busy = 1.
REQ-023 In IDLE: io_out = proj_io_out[active]; io_oeb = oeb_reg; proj_io_in[active] = io_in, all others 0.
REQ-024 OEB writes during busy SHALL be accepted but take effect on pads only in IDLE.
REQ-025 ACTIVE read SHALL return {27'b0, busy, active[3:0]}.

Reset
REQ-026 On wb_rst_i: active = 0, oeb_reg = all ones, sw_rst = 0, error flags = 0, switch_count = 0, FSM = IDLE, wbs_ack_o = 0, wbs_dat_o = 0, switch_busy = 0.
REQ-027 wb_rst_i SHALL assert proj_rst all ones asynchronously while high; reset mid-switch SHALL abort to IDLE without incrementing switch_count.

Verification
REQ-028 Reset then read 0x0C -> ack 1 cycle later, data 0x00000000; io_oeb all ones, io_out 0.
REQ-029 Write ACTIVE=3 -> switch_busy 1 for 1+SWITCH_RST_CYCLES cycles, proj_rst[3] high exactly SWITCH_RST_CYCLES cycles, then io_out = proj_io_out slice 3, STATUS count = 1.
REQ-030 Write ACTIVE=9 with NUM_PROJECTS=8 -> acked, active unchanged, STATUS bit 5 set; write STATUS -> bit cleared.
REQ-031 Write ACTIVE=2 while switching -> acked, ignored, busy_err set; OEB_LO=0 with sel=4'h3 -> no change.
REQ-032 Hold cyc/stb high on read of 0x00 for 4 cycles -> ack pattern 0,1,0,1; unmapped offset 0x14 -> never acked.
REQ-033 Assert wb_rst_i mid-RESET state -> immediate proj_rst all ones, FSM IDLE, active 0, switch_count 0.

Source files
------------

// File: rtl/project_select_ctrl.sv
// Wishbone-controlled multiplexer that connects one of NUM_PROJECTS user projects to the IO pads,
// isolating the pads and holding the incoming project in reset while a switch is in progress.
module project_select_ctrl #(
  parameter int          NUM_PROJECTS      = 8,
  parameter int          IO_PADS           = 38,
  parameter logic [31:0] BASE_ADDR         = 32'h3000_0000,
  parameter int          SWITCH_RST_CYCLES = 16
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  input  logic                               wbs_cyc_i,
  input  logic                               wbs_stb_i,
  input  logic                               wbs_we_i,
  input  logic [3:0]                         wbs_sel_i,
  input  logic [31:0]                        wbs_adr_i,
  input  logic [31:0]                        wbs_dat_i,
  output logic                               wbs_ack_o,
  output logic [31:0]                        wbs_dat_o,
  input  logic [IO_PADS-1:0]                 io_in,
  output logic [IO_PADS-1:0]                 io_out,
  output logic [IO_PADS-1:0]                 io_oeb,
  output logic [NUM_PROJECTS*IO_PADS-1:0]    proj_io_in,
  input  logic [NUM_PROJECTS*IO_PADS-1:0]    proj_io_out,
  output logic [NUM_PROJECTS-1:0]            proj_rst,
  input  logic                               la_rst_i,
  output logic                               switch_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISOLATE, ST_RESET} state_t;

  state_t                    state, state_next;
  logic [7:0]                rst_cnt;
  logic [3:0]                active;
  logic [IO_PADS-1:0]        oeb_reg;
  logic [NUM_PROJECTS-1:0]   sw_rst, fsm_rst, la_rst;
  logic                      range_err, busy_err;
  logic [7:0]                switch_count;

  logic [31:0] off, rdata;
  logic [63:0] oeb_ext;
  logic        mapped, acc, wr, rd, busy, start, rst_done;

  assign off     = wbs_adr_i - BASE_ADDR;
  assign oeb_ext = 64'(oeb_reg);
  assign busy    = (state != ST_IDLE);
  assign switch_busy = busy;

  always_comb begin
    mapped = 1'b0;
    rdata  = '0;
    case (off)
      32'h00: begin mapped = 1'b1; rdata = {27'b0, busy, active}; end
      32'h04: begin mapped = 1'b1; rdata = oeb_ext[31:0]; end
      32'h08: begin mapped = 1'b1; rdata = oeb_ext[63:32]; end
      32'h0C: begin mapped = 1'b1;
                    rdata = {16'b0, switch_count, busy, busy_err, range_err, 1'b0, active}; end
      32'h10: begin mapped = 1'b1; rdata = 32'(sw_rst); end
      default: ;
    endcase
  end

  // Accepting only when ack is low keeps ack a single-cycle pulse under a held strobe.
  assign acc      = wbs_cyc_i & wbs_stb_i & mapped & ~wbs_ack_o;
  assign wr       = acc & wbs_we_i & (wbs_sel_i != 4'h0);
  assign rd       = acc & ~wbs_we_i;
  assign start    = wr && off == 32'h00 && wbs_sel_i[0] &&
                    wbs_dat_i[7:0] < 8'(NUM_PROJECTS) && !busy;
  assign rst_done = (state == ST_RESET) && (rst_cnt == 8'(SWITCH_RST_CYCLES - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_ISOLATE;
      ST_ISOLATE: state_next = ST_RESET;
      ST_RESET:   if (rst_done) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      rst_cnt <= '0;
    end else begin
      state   <= state_next;
      rst_cnt <= (state == ST_RESET) ? rst_cnt + 8'd1 : '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      active       <= '0;
      oeb_reg      <= '1;
      sw_rst       <= '0;
      range_err    <= 1'b0;
      busy_err     <= 1'b0;
      switch_count <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rdata : '0;
      if (rst_done) switch_count <= switch_count + 8'd1;
      if (wr) begin
        case (off)
          32'h00: if (wbs_sel_i[0]) begin
            if (wbs_dat_i[7:0] >= 8'(NUM_PROJECTS)) range_err <= 1'b1;
            else if (busy)                          busy_err  <= 1'b1;
            else                                    active    <= wbs_dat_i[3:0];
          end
          32'h04: if (wbs_sel_i == 4'hF) oeb_reg[31:0] <= wbs_dat_i;
          32'h08: if (wbs_sel_i == 4'hF) oeb_reg[IO_PADS-1:32] <= wbs_dat_i[IO_PADS-33:0];
          32'h0C: begin range_err <= 1'b0; busy_err <= 1'b0; end
          32'h10: sw_rst <= wbs_dat_i[NUM_PROJECTS-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    io_out     = '0;
    io_oeb     = '1;
    proj_io_in = '0;
    fsm_rst    = '0;
    la_rst     = '0;
    if (state == ST_IDLE) io_oeb = oeb_reg;
    for (int unsigned p = 0; p < NUM_PROJECTS; p++) begin
      if (active == 4'(p)) begin
        if (state == ST_IDLE) begin
          io_out = proj_io_out[p*IO_PADS +: IO_PADS];
          proj_io_in[p*IO_PADS +: IO_PADS] = io_in;
        end
        fsm_rst[p] = (state == ST_RESET);
        la_rst[p]  = la_rst_i;
      end
    end
  end

  assign proj_rst = wb_rst_i ? '1 : (sw_rst | fsm_rst | la_rst);

endmodule

// File: tb/tb_project_select_ctrl.sv
// Directed self-checking bench for project_select_ctrl with default parameters.
module tb_project_select_ctrl;
  localparam int NP = 8;
  localparam int IP = 38;
  localparam int NR = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              clk = 1'b0, rst = 1'b1;
  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]        sel = 4'h0;
  logic [31:0]       adr = '0, wdat = '0;
  logic              ack;
  logic [31:0]       rdat_o;
  logic [IP-1:0]     io_in = 38'h2A_1234_5678;
  logic [IP-1:0]     io_out, io_oeb;
  logic [NP*IP-1:0]  proj_io_in, proj_io_out;
  logic [NP-1:0]     proj_rst;
  logic              la_rst = 1'b0;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  project_select_ctrl #(.NUM_PROJECTS(NP), .IO_PADS(IP), .BASE_ADDR(BASE),
                        .SWITCH_RST_CYCLES(NR)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .proj_io_in(proj_io_in),
    .proj_io_out(proj_io_out), .proj_rst(proj_rst), .la_rst_i(la_rst), .switch_busy(busy));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [IP-1:0] pattern(input int p);
    return (p == 0) ? '0 : {6'(p + 1), 32'hC0DE_0000 + 32'(p)};
  endfunction

  task automatic xfer(input logic [7:0] offs, input logic w, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] r, output logic acked);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = BASE + 32'(offs); wdat = d;
    acked = 1'b0; r = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1'b1; r = rdat_o; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wr(input string tag, input logic [7:0] offs, input logic [3:0] s,
                    input logic [31:0] d);
    logic [31:0] r; logic a;
    xfer(offs, 1'b1, s, d, r, a);
    check({tag, "_ack"}, 64'(a), 64'd1);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] offs, input logic [31:0] exp);
    logic [31:0] r; logic a;
    xfer(offs, 1'b0, 4'hF, 32'h0, r, a);
    check({tag, "_ack"}, 64'(a), 64'd1);
    check(tag, 64'(r), 64'(exp));
  endtask

  initial begin
    logic [31:0] r;
    logic        a;
    logic [3:0]  pat;
    int          bcnt, rcnt;

    for (int p = 0; p < NP; p++) proj_io_out[p*IP +: IP] = pattern(p);

    #1;
    check("rst_proj_rst", 64'(proj_rst), 64'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_oeb", 64'(io_oeb), {26'b0, {IP{1'b1}}});
    check("rst_io_out", 64'(io_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_dat", 64'(rdat_o), 64'd0);
    check("rst_proj_rst_rel", 64'(proj_rst), 64'd0);
    rd_check("status_after_rst", 8'h0C, 32'h0);
    check("pin0_after_rst", 64'(proj_io_in[0 +: IP]), 64'(io_in));

    // Switch to project 3 and measure the busy and reset windows
    wr("act3", 8'h00, 4'h1, 32'h3);
    bcnt = 0; rcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bcnt++;
      if (proj_rst[3]) rcnt++;
      if (busy) begin
        check("iso_io_out", 64'(io_out), 64'd0);
      end
      @(posedge clk); #1;
    end
    check("busy_cycles", 64'(bcnt), 64'(1 + NR));
    check("rst3_cycles", 64'(rcnt), 64'(NR));
    check("io_out_p3", 64'(io_out), 64'(pattern(3)));
    check("pin_p3", 64'(proj_io_in[3*IP +: IP]), 64'(io_in));
    check("pin_p0_zero", 64'(proj_io_in[0 +: IP]), 64'd0);
    rd_check("status_cnt1", 8'h0C, 32'h0103);
    rd_check("active_rd", 8'h00, 32'h3);

    wr("oeb_lo", 8'h04, 4'hF, 32'h0000_FFFF);
    wr("oeb_hi", 8'h08, 4'hF, 32'h15);
    check("oeb_full", 64'(io_oeb), 64'h15_0000_FFFF);
    wr("oeb_lo_part", 8'h04, 4'h3, 32'h0);
    check("oeb_partial", 64'(io_oeb), 64'h15_0000_FFFF);

    wr("act9", 8'h00, 4'h1, 32'h9);
    rd_check("status_range", 8'h0C, 32'h0123);
    wr("stat_clr", 8'h0C, 4'hF, 32'h0);
    rd_check("status_cleared", 8'h0C, 32'h0103);

    wr("act5", 8'h00, 4'h1, 32'h5);
    check("busy_oeb", 64'(io_oeb), {26'b0, {IP{1'b1}}});
    wr("act2_busy", 8'h00, 4'h1, 32'h2);
    wr("oeb_lo_busy", 8'h04, 4'hF, 32'h1234_5678);
    check("busy_oeb_held", 64'(io_oeb), {26'b0, {IP{1'b1}}});
    rd_check("status_busy", 8'h0C, 32'h01C5);
    a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin a = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("busy_timeout", 64'(a), 64'd1);
    check("oeb_after_busy", 64'(io_oeb), 64'h15_1234_5678);
    check("io_out_p5", 64'(io_out), 64'(pattern(5)));
    rd_check("status_cnt2", 8'h0C, 32'h0245);

    wr("swrst", 8'h10, 4'hF, 32'h81);
    check("swrst_rst", 64'(proj_rst), 64'h81);
    la_rst = 1'b1; #1;
    check("la_rst", 64'(proj_rst), 64'hA1);
    la_rst = 1'b0;
    wr("swrst_clr", 8'h10, 4'hF, 32'h0);
    check("swrst_cleared", 64'(proj_rst), 64'h0);

    // Held strobe on a mapped read; ack must toggle
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE;
    pat[3] = ack;
    for (int i = 2; i >= 0; i--) begin
      @(posedge clk); #1;
      pat[i] = ack;
      if (ack) check("held_rd_dat", 64'(rdat_o), 64'h5);
    end
    cyc = 1'b0; stb = 1'b0;
    check("ack_pattern", 64'(pat), 64'b0101);
    xfer(8'h14, 1'b0, 4'hF, 32'h0, r, a);
    check("unmapped_ack", 64'(a), 64'd0);

    wr("act1", 8'h00, 4'h1, 32'h1);
    repeat (5) @(posedge clk);
    #3;
    check("mid_reset_state", 64'(proj_rst), 64'h02);
    rst = 1'b1; #1;
    check("abort_proj_rst", 64'(proj_rst), 64'hFF);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    rd_check("status_abort", 8'h0C, 32'h0);
    rd_check("active_abort", 8'h00, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
